// File: rtl/uart_pkg.sv
// Shared UART constants: data byte width and the tagged receive-entry width.
package uart_pkg;
    localparam int UART_DATA_W  = 8;
    localparam int UART_ENTRY_W = UART_DATA_W + 1;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: storage array plus wrap-bit pointers.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == (AW+1)'(DEPTH));
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: tags each byte with its BREAK flag, queues it and
// records dropped bytes in a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   recv_valid,
    input  logic [UART_DATA_W-1:0] recv_data,
    input  logic                   recv_break,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_break,
    output logic [AW:0]            level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_overflow
);
    logic                    push_s;
    logic                    pop_s;
    logic                    drop_s;
    logic [UART_ENTRY_W-1:0] head_s;
    logic                    overflow_q, overflow_d;

    uart_sync_fifo #(
        .WIDTH (UART_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .wdata  ({recv_break, recv_data}),
        .pop    (pop_s),
        .rdata  (head_s),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    always_comb begin
        pop_s  = !empty && rd_ready;
        push_s = recv_valid && (!full || pop_s);
        drop_s = recv_valid && !push_s;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign rd_valid = !empty;
    assign rd_data  = head_s[UART_DATA_W-1:0];
    assign rd_break = head_s[UART_DATA_W];
    assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised plus directed bench for uart_rx_fifo, checked against a queue model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          recv_valid = 1'b0;
    logic [7:0]    recv_data = 8'h00;
    logic          recv_break = 1'b0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_break;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [8:0] model_q[$];
    logic       ovf_m = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .recv_valid   (recv_valid),
        .recv_data    (recv_data),
        .recv_break   (recv_break),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_break     (rd_break),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the model mid-cycle, then applies the coming edge to the model.
    always @(negedge clk) begin
        int  sz;
        bit  pop_m;
        bit  push_m;
        if (!resetn) begin
            model_q.delete();
            ovf_m = 1'b0;
            check("rst_level", 32'(level), 32'd0);
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_full", 32'(full), 32'd0);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
        end else begin
            sz = model_q.size();
            check("level", 32'(level), 32'(sz));
            check("full", 32'(full), 32'(sz == DEPTH));
            check("empty", 32'(empty), 32'(sz == 0));
            check("rd_valid", 32'(rd_valid), 32'(sz != 0));
            check("overflow", 32'(overflow), 32'(ovf_m));
            pop_m = (sz != 0) && rd_ready;
            if (sz != 0) begin
                check("head_entry", 32'({rd_break, rd_data}), 32'(model_q[0]));
            end
            if (pop_m) begin
                void'(model_q.pop_front());
            end
            push_m = recv_valid && ((sz < DEPTH) || pop_m);
            if (push_m) begin
                model_q.push_back({recv_break, recv_data});
            end
            if (recv_valid && !push_m) ovf_m = 1'b1;
            else if (clr_overflow) ovf_m = 1'b0;
        end
    end

    task automatic cyc(input bit rv, input logic [7:0] d, input bit brk, input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        recv_valid   = rv;
        recv_data    = d;
        recv_break   = brk;
        rd_ready     = rdy;
        clr_overflow = clr;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, rdy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        recv_valid = 1'b0;
        rd_ready   = 1'b0;
        clr_overflow = 1'b0;
        resetn     = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Three bytes, held, then drained
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("three_level", 32'(level), 32'd3);
        check("three_head", 32'(rd_data), 32'h41);
        idle(4, 1'b1);

        // Overfill by one byte, then drain
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        idle(18, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("pp_level", 32'(level), 32'd16);
        check("pp_ovf", 32'(overflow), 32'd0);
        idle(18, 1'b1);

        // BREAK-tagged entry between two plain bytes
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b1);

        // Drop coincident with clear keeps overflow set
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i * 3), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        check("clr_ovf", 32'(overflow), 32'd0);
        idle(18, 1'b1);

        // Reset mid-stream discards entries
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        pulse_reset();
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("post_rst_head", 32'(rd_data), 32'h55);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 80)),
                    1'($urandom_range(0, 19) == 0));
            end
        end
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
